fifo_mem_sync: RTL and testbench

//  Next-generation FIFO storage array for single-clock FIFOs: synchronous write with per-lane

---
 rtl/fifo_mem_sync.sv | 156 +++++++++++++++
 tb/tb_fifo_mem_sync.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_mem_sync.sv
// Single-clock FIFO storage array: lane-masked synchronous write, registered read with optional
// second output stage and selectable read-during-write forwarding. Parity via FIFO_MEM_PARITY_EN.
module fifo_mem_sync #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_SIZE  = 3,
    parameter int LANE_WIDTH = 8,
    parameter int OUT_REG    = 0,
    parameter int BYPASS     = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               w_en,
    input  logic [ADDR_SIZE-1:0]               w_addr,
    input  logic [DATA_WIDTH/LANE_WIDTH-1:0]   w_be,
    input  logic [DATA_WIDTH-1:0]              data,
    input  logic                               r_en,
    input  logic [ADDR_SIZE-1:0]               r_addr,
    output logic [DATA_WIDTH-1:0]              out,
    output logic                               r_valid
`ifdef FIFO_MEM_PARITY_EN
    ,
    output logic                               parity_err,
    input  logic [DATA_WIDTH/LANE_WIDTH-1:0]   w_par_flip
`endif
);

    localparam int NUM_LANES = DATA_WIDTH / LANE_WIDTH;
    localparam int DEPTH     = 1 << ADDR_SIZE;

    // r_en is a request without backpressure: each accepted request yields exactly one
    // r_valid pulse, and out carries that request's data in the same cycle as the pulse.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  fwd_hit;
    logic                  s1_valid_d, s1_valid_q;
    logic [DATA_WIDTH-1:0] s1_data_d, s1_data_q;

    assign fwd_hit = w_en && (w_addr == r_addr) && (BYPASS != 0);

    always_comb begin
        rd_word = mem_q[r_addr];
        for (int i = 0; i < NUM_LANES; i++) begin
            if (fwd_hit && w_be[i]) begin
                rd_word[i*LANE_WIDTH +: LANE_WIDTH] = data[i*LANE_WIDTH +: LANE_WIDTH];
            end
        end
    end

    always_comb begin
        s1_valid_d = r_en;
        s1_data_d  = r_en ? rd_word : s1_data_q;
    end

    always_ff @(posedge clk) begin
        if (!rst && w_en) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (w_be[i]) begin
                    mem_q[w_addr][i*LANE_WIDTH +: LANE_WIDTH] <= data[i*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
        end
    end

`ifdef FIFO_MEM_PARITY_EN
    // Stored bit is lane parity XOR flip, so a flipped lane mismatches on every later read.
    logic [NUM_LANES-1:0] par_q [DEPTH];
    logic [NUM_LANES-1:0] wr_par, rd_par, rd_chk;
    logic                 s1_perr_d, s1_perr_q;

    always_comb begin
        rd_par = par_q[r_addr];
        for (int i = 0; i < NUM_LANES; i++) begin
            wr_par[i] = (^data[i*LANE_WIDTH +: LANE_WIDTH]) ^ w_par_flip[i];
            rd_chk[i] = ^rd_word[i*LANE_WIDTH +: LANE_WIDTH];
            if (fwd_hit && w_be[i]) begin
                rd_par[i] = wr_par[i];
            end
        end
        s1_perr_d = r_en && (rd_chk != rd_par);
    end

    always_ff @(posedge clk) begin
        if (!rst && w_en) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (w_be[i]) begin
                    par_q[w_addr][i] <= wr_par[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_perr_q <= 1'b0;
        end else begin
            s1_perr_q <= s1_perr_d;
        end
    end
`endif

    if (OUT_REG != 0) begin : g_out_reg
        logic                  s2_valid_d, s2_valid_q;
        logic [DATA_WIDTH-1:0] s2_data_d, s2_data_q;

        always_comb begin
            s2_valid_d = s1_valid_q;
            s2_data_d  = s1_data_q;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                s2_valid_q <= 1'b0;
                s2_data_q  <= '0;
            end else begin
                s2_valid_q <= s2_valid_d;
                s2_data_q  <= s2_data_d;
            end
        end

        assign out     = s2_data_q;
        assign r_valid = s2_valid_q;

`ifdef FIFO_MEM_PARITY_EN
        logic s2_perr_d, s2_perr_q;

        always_comb s2_perr_d = s1_perr_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                s2_perr_q <= 1'b0;
            end else begin
                s2_perr_q <= s2_perr_d;
            end
        end

        assign parity_err = s2_perr_q;
`endif
    end else begin : g_no_out_reg
        assign out     = s1_data_q;
        assign r_valid = s1_valid_q;
`ifdef FIFO_MEM_PARITY_EN
        assign parity_err = s1_perr_q;
`endif
    end

endmodule

// File: tb/tb_fifo_mem_sync.sv
// Bench for fifo_mem_sync: default, 32-bit latency-1 bypass, and 32-bit latency-2 no-bypass
// instances share stimulus; checked by a directed table, hand sequences and a random model run.
module tb_fifo_mem_sync;

    logic        clk = 1'b0;
    logic        rst;
    logic        w_en;
    logic [2:0]  w_addr;
    logic [3:0]  w_be;
    logic [31:0] data;
    logic        r_en;
    logic [2:0]  r_addr;
    logic [3:0]  w_par_flip;

    logic [7:0]  out_def;
    logic        v_def;
    logic [31:0] out_w;
    logic        v_w;
    logic [31:0] out_r;
    logic        v_r;
`ifdef FIFO_MEM_PARITY_EN
    logic        perr_def, perr_w, perr_r;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_mem_sync u_def (
        .clk(clk), .rst(rst), .w_en(w_en), .w_addr(w_addr), .w_be(w_be[0]), .data(data[7:0]),
        .r_en(r_en), .r_addr(r_addr), .out(out_def), .r_valid(v_def)
`ifdef FIFO_MEM_PARITY_EN
        , .parity_err(perr_def), .w_par_flip(w_par_flip[0])
`endif
    );

    fifo_mem_sync #(.DATA_WIDTH(32), .LANE_WIDTH(8), .OUT_REG(0), .BYPASS(1)) u_w (
        .clk(clk), .rst(rst), .w_en(w_en), .w_addr(w_addr), .w_be(w_be), .data(data),
        .r_en(r_en), .r_addr(r_addr), .out(out_w), .r_valid(v_w)
`ifdef FIFO_MEM_PARITY_EN
        , .parity_err(perr_w), .w_par_flip(w_par_flip)
`endif
    );

    fifo_mem_sync #(.DATA_WIDTH(32), .LANE_WIDTH(8), .OUT_REG(1), .BYPASS(0)) u_r (
        .clk(clk), .rst(rst), .w_en(w_en), .w_addr(w_addr), .w_be(w_be), .data(data),
        .r_en(r_en), .r_addr(r_addr), .out(out_r), .r_valid(v_r)
`ifdef FIFO_MEM_PARITY_EN
        , .parity_err(perr_r), .w_par_flip(w_par_flip)
`endif
    );

    // Reference model: word array plus per-lane flip marks, and the expected visible outputs.
    logic [31:0] mem_m  [8];
    logic [3:0]  flip_m [8];
    logic [31:0] e_w_d = '0, e_r1_d = '0, e_r_d = '0;
    logic        e_w_v = 1'b0, e_r1_v = 1'b0, e_r_v = 1'b0;
    logic        e_w_p = 1'b0, e_def_p = 1'b0, e_r1_p = 1'b0, e_r_p = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%b want=%b", name, act, exp);
        end
    endtask

    task automatic step(input logic rst_i, input logic we, input logic [2:0] wa,
                        input logic [3:0] be, input logic [31:0] d, input logic [3:0] fl,
                        input logic re, input logic [2:0] ra);
        logic [31:0] old_w, byp_w;
        logic [3:0]  old_f, byp_f;
        rst = rst_i; w_en = we; w_addr = wa; w_be = be; data = d; w_par_flip = fl;
        r_en = re; r_addr = ra;
        old_w = mem_m[ra];
        old_f = flip_m[ra];
        byp_w = old_w;
        byp_f = old_f;
        if (we && wa == ra) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    byp_w[8*i +: 8] = d[8*i +: 8];
                    byp_f[i] = fl[i];
                end
            end
        end
        if (rst_i) begin
            e_w_d = '0; e_w_v = 1'b0; e_w_p = 1'b0; e_def_p = 1'b0;
            e_r1_d = '0; e_r1_v = 1'b0; e_r1_p = 1'b0;
            e_r_d = '0; e_r_v = 1'b0; e_r_p = 1'b0;
        end else begin
            e_r_d = e_r1_d; e_r_v = e_r1_v; e_r_p = e_r1_p;
            if (re) begin
                e_w_d = byp_w; e_w_v = 1'b1; e_w_p = |byp_f; e_def_p = byp_f[0];
                e_r1_d = old_w; e_r1_v = 1'b1; e_r1_p = |old_f;
            end else begin
                e_w_v = 1'b0; e_w_p = 1'b0; e_def_p = 1'b0;
                e_r1_v = 1'b0; e_r1_p = 1'b0;
            end
            if (we) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) begin
                        mem_m[wa][8*i +: 8] = d[8*i +: 8];
                        flip_m[wa][i] = fl[i];
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        chk("def_out", {24'd0, out_def}, {24'd0, e_w_d[7:0]});
        chk1("def_valid", v_def, e_w_v);
        chk("w_out", out_w, e_w_d);
        chk1("w_valid", v_w, e_w_v);
        chk("r_out", out_r, e_r_d);
        chk1("r_valid", v_r, e_r_v);
`ifdef FIFO_MEM_PARITY_EN
        chk1("def_perr", perr_def, e_def_p);
        chk1("w_perr", perr_w, e_w_p);
        chk1("r_perr", perr_r, e_r_p);
`endif
    endtask

    typedef struct {
        logic        rst;
        logic        we;
        logic [2:0]  wa;
        logic [3:0]  be;
        logic [31:0] d;
        logic        re;
        logic [2:0]  ra;
        logic [31:0] w_out;
        logic        w_v;
        logic [31:0] r_out;
        logic        r_v;
    } vec_t;

    vec_t tbl[$];

    initial begin
        rst = 1'b1; w_en = 1'b0; w_addr = '0; w_be = '0; data = '0;
        r_en = 1'b0; r_addr = '0; w_par_flip = '0;
        for (int i = 0; i < 8; i++) begin
            mem_m[i] = '0;
            flip_m[i] = '0;
        end

        // {rst, we, wa, be, d, re, ra, w_out, w_v, r_out, r_v}; expected values after the edge
        tbl.push_back('{1, 0, 0, 4'h0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0});
        tbl.push_back('{0, 1, 3, 4'hF, 32'hA5,       0, 0, 32'h0,        0, 32'h0,        0});
        tbl.push_back('{0, 0, 0, 4'h0, 32'h0,        1, 3, 32'hA5,       1, 32'h0,        0});
        tbl.push_back('{0, 0, 0, 4'h0, 32'h0,        0, 0, 32'hA5,       0, 32'hA5,       1});
        tbl.push_back('{0, 0, 0, 4'h0, 32'h0,        0, 0, 32'hA5,       0, 32'hA5,       0});
        tbl.push_back('{0, 1, 5, 4'hF, 32'h11223344, 0, 0, 32'hA5,       0, 32'hA5,       0});
        tbl.push_back('{0, 1, 5, 4'h5, 32'hAABBCCDD, 0, 0, 32'hA5,       0, 32'hA5,       0});
        tbl.push_back('{0, 0, 0, 4'h0, 32'h0,        1, 5, 32'h11BB33DD, 1, 32'hA5,       0});
        tbl.push_back('{0, 1, 2, 4'hF, 32'h10,       0, 0, 32'h11BB33DD, 0, 32'h11BB33DD, 1});
        tbl.push_back('{0, 1, 2, 4'hF, 32'h77,       1, 2, 32'h77,       1, 32'h11BB33DD, 0});
        tbl.push_back('{0, 0, 0, 4'h0, 32'h0,        0, 0, 32'h77,       0, 32'h10,       1});
        tbl.push_back('{0, 1, 0, 4'hF, 32'h01,       0, 0, 32'h77,       0, 32'h10,       0});
        tbl.push_back('{0, 1, 1, 4'hF, 32'h02,       0, 0, 32'h77,       0, 32'h10,       0});
        tbl.push_back('{0, 1, 2, 4'hF, 32'h03,       0, 0, 32'h77,       0, 32'h10,       0});
        tbl.push_back('{0, 0, 0, 4'h0, 32'h0,        1, 0, 32'h01,       1, 32'h10,       0});
        tbl.push_back('{0, 0, 0, 4'h0, 32'h0,        1, 1, 32'h02,       1, 32'h01,       1});
        tbl.push_back('{0, 0, 0, 4'h0, 32'h0,        1, 2, 32'h03,       1, 32'h02,       1});
        tbl.push_back('{0, 0, 0, 4'h0, 32'h0,        0, 0, 32'h03,       0, 32'h03,       1});
        tbl.push_back('{0, 1, 4, 4'hF, 32'hCAFEF00D, 0, 0, 32'h03,       0, 32'h03,       0});
        tbl.push_back('{0, 0, 0, 4'h0, 32'h0,        1, 4, 32'hCAFEF00D, 1, 32'h03,       0});
        tbl.push_back('{1, 0, 0, 4'h0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0});
        tbl.push_back('{1, 1, 4, 4'hF, 32'hDEAD0000, 1, 4, 32'h0,        0, 32'h0,        0});
        tbl.push_back('{0, 0, 0, 4'h0, 32'h0,        1, 4, 32'hCAFEF00D, 1, 32'h0,        0});
        tbl.push_back('{0, 0, 0, 4'h0, 32'h0,        0, 0, 32'hCAFEF00D, 0, 32'hCAFEF00D, 1});

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].we, tbl[i].wa, tbl[i].be, tbl[i].d, 4'h0, tbl[i].re, tbl[i].ra);
            chk("tbl_w_out", out_w, tbl[i].w_out);
            chk1("tbl_w_valid", v_w, tbl[i].w_v);
            chk("tbl_r_out", out_r, tbl[i].r_out);
            chk1("tbl_r_valid", v_r, tbl[i].r_v);
        end

        // Partial-lane same-edge write and read: forwarded lanes only on the bypass instance.
        step(0, 1, 3'd6, 4'hF, 32'h01020304, 4'h0, 0, 3'd0);
        step(0, 1, 3'd7, 4'hF, 32'h5A5A5A5A, 4'h0, 0, 3'd0);
        step(0, 1, 3'd6, 4'b0011, 32'hFFFFFFFF, 4'h0, 1, 3'd6);
        chk("byp_partial_w", out_w, 32'h0102FFFF);
        step(0, 0, 3'd0, 4'h0, 32'h0, 4'h0, 0, 3'd0);
        chk("byp_old_r", out_r, 32'h01020304);
        chk1("byp_old_r_valid", v_r, 1'b1);
        step(0, 0, 3'd0, 4'h0, 32'h0, 4'h0, 1, 3'd6);
        chk("after_write_w", out_w, 32'h0102FFFF);

`ifdef FIFO_MEM_PARITY_EN
        step(0, 1, 3'd1, 4'hF, 32'h3C, 4'b0001, 0, 3'd0);
        step(0, 0, 3'd0, 4'h0, 32'h0, 4'h0, 1, 3'd1);
        chk("par_flip_out", out_w, 32'h3C);
        chk1("par_flip_err", perr_w, 1'b1);
        step(0, 1, 3'd1, 4'hF, 32'h3C, 4'h0, 0, 3'd0);
        step(0, 0, 3'd0, 4'h0, 32'h0, 4'h0, 1, 3'd1);
        chk1("par_clean_err", perr_w, 1'b0);
`endif

        for (int n = 0; n < 400; n++) begin
            logic [3:0] fl;
            fl = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            step(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 4'($urandom_range(0, 15)), $urandom, fl, 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
